// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit positions and TX launcher state encoding
// for the UART bus bridge.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_CLEAR  = 2'd3;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_OVERRUN  = 4;
  localparam int ST_BREAK    = 5;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  // Last count value in WAIT_BUSY before giving up on tx_busy (4 cycles total).
  localparam logic [1:0] TX_TIMEOUT_LAST = 2'd3;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_LAUNCH    = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head visible combinationally on dout.
// A push on a full FIFO is only accepted when a pop frees the slot in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// Memory-mapped bridge between a simple CPU bus and a byte UART: TX/RX FIFOs,
// sticky error flags, interrupt enables and a one-shot TX launcher.
module uart_bus_bridge
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_wen,
  input  logic        bus_ren,
  output logic [31:0] bus_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_break,
  output logic        irq
);
  logic        in_win, wr, rd, clr_wr;
  logic [1:0]  reg_sel;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_dout, rx_dout;
  logic        rx_pop, rx_full, rx_empty, rx_overflow;
  logic [5:0]  status;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        overrun_q, overrun_d, break_q, break_d;
  tx_state_e   state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        unused_bits;

  assign unused_bits = ^{bus_wdata[31:8], bus_addr[1:0]};

  assign in_win  = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel = bus_addr[3:2];
  assign wr      = bus_wen & in_win;
  assign rd      = bus_ren & ~bus_wen & in_win;
  assign clr_wr  = wr && (reg_sel == REG_CLEAR);

  assign tx_push     = wr && (reg_sel == REG_DATA) && !tx_full;
  assign rx_pop      = rd && (reg_sel == REG_DATA) && !rx_empty;
  assign rx_overflow = rx_valid & rx_full & ~rx_pop;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus_wdata[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_valid), .pop(rx_pop), .din(rx_data),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    status              = '0;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_OVERRUN]  = overrun_q;
    status[ST_BREAK]    = break_q;
  end

  // A same-cycle set wins over a CLEAR write.
  assign overrun_d = (overrun_q & ~(clr_wr & bus_wdata[0])) | rx_overflow;
  assign break_d   = (break_q & ~(clr_wr & bus_wdata[1])) | rx_break;
  assign ctrl_d    = (wr && reg_sel == REG_CTRL) ? bus_wdata[1:0] : ctrl_q;

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      case (reg_sel)
        REG_DATA:   rdata_d = {24'b0, rx_empty ? 8'h00 : rx_dout};
        REG_STATUS: rdata_d = {26'b0, status};
        REG_CTRL:   rdata_d = {30'b0, ctrl_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  // TX launcher: head byte is latched on entry to LAUNCH and popped while there.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_pop    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!tx_empty && !tx_busy) begin
          state_d   = TX_LAUNCH;
          tx_data_d = tx_dout;
        end
      end
      TX_LAUNCH: begin
        tx_pop  = 1'b1;
        cnt_d   = '0;
        state_d = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (tx_busy)                      state_d = TX_WAIT_DONE;
        else if (cnt_q == TX_TIMEOUT_LAST) state_d = TX_IDLE;
        else                              cnt_d   = cnt_q + 2'd1;
      end
      TX_WAIT_DONE: begin
        if (!tx_busy) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q   <= '0;
      ctrl_q    <= '0;
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      tx_data_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      overrun_q <= overrun_d;
      break_q   <= break_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign tx_data   = tx_data_q;
  assign tx_en     = (state_q == TX_LAUNCH);
  assign irq       = (~rx_empty & ctrl_q[CTRL_RX_IE]) | (tx_empty & ctrl_q[CTRL_TX_IE]);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: bus register access, TX launcher, RX overrun, irq and reset.
module tb_uart_bus_bridge;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;
  localparam logic [31:0] A_CLR  = BASE + 32'hC;

  logic        clk, rst;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_wen, bus_ren;
  logic [7:0]  tx_data, rx_data;
  logic        tx_en, tx_busy, rx_valid, rx_break, irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic force_busy, model_en;
  int   busy_cnt;
  logic [7:0] txq[$];
  int   txcyc[$];
  int   wide;
  logic prev_en;

  uart_bus_bridge #(.BASE_ADDR(BASE), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_rdata(bus_rdata),
    .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_break(rx_break), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy for 10 cycles after each accepted start pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (model_en && tx_en) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy | (busy_cnt != 0);

  always @(negedge clk) begin
    if (tx_en) begin
      if (prev_en) wide++;
      else begin
        txq.push_back(tx_data);
        txcyc.push_back(cyc);
      end
    end
    prev_en = tx_en;
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_wen = 1'b1;
    @(negedge clk);
    bus_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_ren = 1'b1;
    @(negedge clk);
    bus_ren = 1'b0;
    d = bus_rdata;
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && txq.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus_rdata); end
    checks++; if (tx_en !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx: got en=%b data=%h expected 0/00", tx_en, tx_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rst = 1'b0;
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL reset_status: got %h expected 5", d); end
  endtask

  task automatic test_tx_basic;
    model_en = 1'b1; force_busy = 1'b0;
    txq.delete(); wide = 0;
    bus_write(A_DATA, 32'h41);
    bus_write(A_DATA, 32'h42);
    wait_tx(2, 100);
    repeat (20) @(negedge clk);
    checks++;
    if (txq.size() != 2) begin errors++; $display("FAIL tx_basic_count: got %0d expected 2", txq.size()); end
    else if (txq[0] !== 8'h41 || txq[1] !== 8'h42) begin errors++; $display("FAIL tx_basic_bytes: got %h %h expected 41 42", txq[0], txq[1]); end
    checks++; if (wide != 0) begin errors++; $display("FAIL tx_pulse_width: got %0d wide pulses expected 0", wide); end
    checks++; if (tx_data !== 8'h42 || tx_en !== 1'b0) begin errors++; $display("FAIL tx_hold: got data=%h en=%b expected 42/0", tx_data, tx_en); end
  endtask

  task automatic test_tx_timeout;
    model_en = 1'b0; force_busy = 1'b0;
    txq.delete(); txcyc.delete();
    bus_write(A_DATA, 32'hA1);
    bus_write(A_DATA, 32'hA2);
    wait_tx(2, 60);
    checks++;
    if (txq.size() != 2) begin errors++; $display("FAIL timeout_count: got %0d expected 2", txq.size()); end
    else if (txq[1] !== 8'hA2 || txcyc[1] - txcyc[0] != 6) begin
      errors++; $display("FAIL timeout_gap: got byte %h gap %0d expected A2 gap 6", txq[1], txcyc[1] - txcyc[0]);
    end
  endtask

  task automatic test_tx_full;
    logic [31:0] d;
    force_busy = 1'b1; model_en = 1'b0;
    repeat (8) @(negedge clk);
    txq.delete();
    for (int i = 0; i < 8; i++) bus_write(A_DATA, 32'h10 + i);
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL tx_full_status: got %h expected 6", d); end
    bus_write(A_DATA, 32'h99);
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL tx_drop_status: got %h expected 6", d); end
    force_busy = 1'b0; model_en = 1'b1;
    wait_tx(8, 400);
    repeat (30) @(negedge clk);
    checks++; if (txq.size() != 8) begin errors++; $display("FAIL tx_full_sent: got %0d bytes expected 8", txq.size()); end
    for (int i = 0; i < 8 && i < txq.size(); i++) begin
      checks++;
      if (txq[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL tx_full_byte%0d: got %h expected %h", i, txq[i], 8'(8'h10 + i)); end
    end
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL tx_drained_status: got %h expected 5", d); end
  endtask

  task automatic test_rx_overrun;
    logic [31:0] d;
    for (int i = 1; i <= 9; i++) rx_push(8'(i));
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h19) begin errors++; $display("FAIL overrun_status: got %h expected 19", d); end
    for (int i = 1; i <= 8; i++) begin
      bus_read(A_DATA, d);
      checks++; if (d !== 32'(i)) begin errors++; $display("FAIL overrun_read%0d: got %h expected %h", i, d, i); end
    end
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL empty_read: got %h expected 0", d); end
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h15) begin errors++; $display("FAIL drained_status: got %h expected 15", d); end
    bus_write(A_CLR, 32'h1);
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL overrun_clear: got %h expected 5", d); end
  endtask

  task automatic test_rx_simul;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) rx_push(8'(8'h21 + i));
    @(negedge clk);
    rx_data = 8'h09; rx_valid = 1'b1; bus_addr = A_DATA; bus_ren = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; bus_ren = 1'b0;
    checks++; if (bus_rdata !== 32'h21) begin errors++; $display("FAIL simul_read: got %h expected 21", bus_rdata); end
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h09) begin errors++; $display("FAIL simul_status: got %h expected 09", d); end
    for (int i = 1; i < 8; i++) bus_read(A_DATA, d);
    checks++; if (d !== 32'h28) begin errors++; $display("FAIL simul_last_old: got %h expected 28", d); end
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h09) begin errors++; $display("FAIL simul_retained: got %h expected 09", d); end
  endtask

  task automatic test_irq_break;
    logic [31:0] d;
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h1 || irq !== 1'b0) begin errors++; $display("FAIL ctrl_rx_ie: got ctrl=%h irq=%b expected 1/0", d, irq); end
    rx_push(8'hAB);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx: got %b expected 1", irq); end
    bus_read(A_DATA, d);
    checks++; if (irq !== 1'b0 || d !== 32'hAB) begin errors++; $display("FAIL irq_pop: got irq=%b data=%h expected 0/AB", irq, d); end
    bus_write(A_CTRL, 32'h2);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx: got %b expected 1", irq); end
    bus_write(A_CTRL, 32'h0);
    @(negedge clk); rx_break = 1'b1;
    @(negedge clk); rx_break = 1'b0;
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h25) begin errors++; $display("FAIL break_set: got %h expected 25", d); end
    @(negedge clk);
    rx_break = 1'b1; bus_addr = A_CLR; bus_wdata = 32'h2; bus_wen = 1'b1;
    @(negedge clk);
    rx_break = 1'b0; bus_wen = 1'b0;
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h25) begin errors++; $display("FAIL break_set_wins: got %h expected 25", d); end
    bus_write(A_CLR, 32'h2);
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL break_clear: got %h expected 5", d); end
  endtask

  task automatic test_window;
    logic [31:0] d;
    force_busy = 1'b1; model_en = 1'b0;
    txq.delete();
    bus_write(BASE + 32'h10, 32'h33);
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL window_write: got %h expected 5", d); end
    bus_read(BASE + 32'h14, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL window_read_hold: got %h expected 5", d); end
    rx_push(8'h66);
    @(negedge clk);
    bus_addr = A_DATA; bus_wdata = 32'h77; bus_wen = 1'b1; bus_ren = 1'b1;
    @(negedge clk);
    bus_wen = 1'b0; bus_ren = 1'b0;
    checks++; if (bus_rdata !== 32'h5) begin errors++; $display("FAIL wr_rd_no_read: got %h expected 5", bus_rdata); end
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wr_rd_status: got %h expected 0", d); end
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h66) begin errors++; $display("FAIL wr_rd_no_pop: got %h expected 66", d); end
    force_busy = 1'b0; model_en = 1'b1;
    wait_tx(1, 60);
    checks++;
    if (txq.size() != 1) begin errors++; $display("FAIL wr_rd_tx_count: got %0d expected 1", txq.size()); end
    else if (txq[0] !== 8'h77) begin errors++; $display("FAIL wr_rd_tx_byte: got %h expected 77", txq[0]); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_launch;
    logic [31:0] d;
    int n;
    model_en = 1'b0; force_busy = 1'b0;
    txq.delete();
    bus_write(A_DATA, 32'h55);
    n = 0;
    while (!tx_en && n < 10) begin @(negedge clk); n++; end
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL launch_seen: got %b expected 1", tx_en); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx_en !== 1'b0 || tx_data !== 8'h00 || bus_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_in_launch: got en=%b data=%h rdata=%h expected 0/00/0", tx_en, tx_data, bus_rdata);
    end
    @(negedge clk); rst = 1'b0;
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL reset_launch_status: got %h expected 5", d); end
    repeat (20) @(negedge clk);
    checks++; if (txq.size() != 1) begin errors++; $display("FAIL reset_discard: got %0d launches expected 1", txq.size()); end
  endtask

  initial begin
    rst = 1'b1; bus_addr = '0; bus_wdata = '0; bus_wen = 1'b0; bus_ren = 1'b0;
    rx_data = '0; rx_valid = 1'b0; rx_break = 1'b0;
    force_busy = 1'b0; model_en = 1'b0; wide = 0; prev_en = 1'b0;
    test_reset();
    test_tx_basic();
    test_tx_timeout();
    test_tx_full();
    test_rx_overrun();
    test_rx_simul();
    test_irq_break();
    test_window();
    test_reset_launch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
